pc_fetch_ctrl: RTL and testbench

Program-counter and fetch-sequencing unit that drives the instruction memory's fetch port (`address`, `PCctrl`, `PChold`). It sits at the front of the IF stage. It owns the PC register, applies hazard-unit stalls and EX-stage branch/jump redirects, and schedules flush bubbles. It also tracks the PC and validity of the instruction presented to the IF/ID register.

---
 rtl/pc_fetch_ctrl_pkg.sv | 26 ++
 rtl/pc_fetch_ctrl_if.sv | 36 +++
 rtl/pc_fetch_ctrl_flush_counter.sv | 41 ++++
 rtl/pc_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_pkg : shared widths and fetch-state encodings
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_fetch_ctrl_pkg;

  localparam int MEM_SPACE = 16;
  localparam int ISIZE     = 32;

  localparam logic [1:0] FS_RUN   = 2'd0;
  localparam logic [1:0] FS_HOLD  = 2'd1;
  localparam logic [1:0] FS_FLUSH = 2'd2;
  localparam logic [1:0] FS_HALT  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = FS_RUN,
    ST_HOLD  = FS_HOLD,
    ST_FLUSH = FS_FLUSH,
    ST_HALT  = FS_HALT
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_if : control inputs and fetch-port outputs of the fetch unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pc_fetch_ctrl_if
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_SPACE
);

  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic [ADDR_W-1:0] address;
  logic              PCctrl;
  logic              PChold;
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
  logic [ADDR_W-1:0] pc_plus1;

  modport master (
    input  stall, redirect, redirect_pc, halt,
    output address, PCctrl, PChold, if_pc, if_valid, pc_plus1
  );

  modport slave (
    output stall, redirect, redirect_pc, halt,
    input  address, PCctrl, PChold, if_pc, if_valid, pc_plus1
  );

endinterface

`default_nettype wire

// File: rtl/pc_fetch_ctrl_flush_counter.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_flush_counter : 2-bit loadable down-counter with zero flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_fetch_ctrl_flush_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [1:0] count_q;
  logic [1:0] count_d;

  // Load dominates decrement; the counter saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 2'd0)) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 2'd0);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl : PC register and fetch sequencer (stall, redirect, flush, halt)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W       = MEM_SPACE,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_fetch_ctrl_if.master       bus
);

  localparam logic [1:0]        FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PC_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  generate
    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 3)) begin : g_bad_flush_cycles
      $error("FLUSH_CYCLES must be in 1..3");
    end
  endgenerate

  fetch_state_e      state_q,    state_d;
  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic              pcctrl_q,   pcctrl_d;
  logic              pchold_q,   pchold_d;
  logic [ADDR_W-1:0] if_pc_q,    if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  pc_fetch_ctrl_flush_counter u_flush_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (FLUSH_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pcctrl_d   = pcctrl_q;
    pchold_d   = pchold_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (bus.halt) begin
      state_d    = ST_HALT;
      pcctrl_d   = 1'b1;
      pchold_d   = 1'b0;
      if_valid_d = 1'b0;
    end else if (bus.redirect) begin
      // A concurrent stall belongs to a younger, squashed instruction.
      state_d    = ST_FLUSH;
      pc_d       = bus.redirect_pc;
      pcctrl_d   = 1'b1;
      pchold_d   = 1'b0;
      if_valid_d = 1'b0;
      cnt_load   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.stall) begin
            state_d  = ST_HOLD;
            pchold_d = 1'b1;
          end else begin
            pc_d       = pc_q + PC_ONE;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!bus.stall) begin
            state_d    = ST_RUN;
            pchold_d   = 1'b0;
            pc_d       = pc_q + PC_ONE;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
          end
        end
        ST_FLUSH: begin
          // PC stays on the target through the exit edge so it is fetched unmasked.
          if (cnt_zero) begin
            state_d  = ST_RUN;
            pcctrl_d = 1'b0;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pcctrl_q   <= 1'b0;
      pchold_q   <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pcctrl_q   <= pcctrl_d;
      pchold_q   <= pchold_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign bus.address  = pc_q;
  assign bus.PCctrl   = pcctrl_q;
  assign bus.PChold   = pchold_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.pc_plus1 = pc_q + PC_ONE;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl : directed vectors for pc_fetch_ctrl (ADDR_W=8, FLUSH_CYCLES=2)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pc_fetch_ctrl_if #(.ADDR_W(8)) bus ();

  pc_fetch_ctrl #(
    .ADDR_W       (8),
    .RESET_PC     (8'h00),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] addr, input logic ctrl,
                            input logic hold, input logic [7:0] ifpc, input logic ifv);
    chk({tag, ".address"},  32'(bus.address),  32'(addr));
    chk({tag, ".PCctrl"},   32'(bus.PCctrl),   32'(ctrl));
    chk({tag, ".PChold"},   32'(bus.PChold),   32'(hold));
    chk({tag, ".if_pc"},    32'(bus.if_pc),    32'(ifpc));
    chk({tag, ".if_valid"}, 32'(bus.if_valid), 32'(ifv));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic r, input logic [7:0] rpc, input logic h);
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.halt        = h;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    step();
    expect_out("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("reset.pc_plus1", 32'(bus.pc_plus1), 32'h01);
    rst = 1'b1;

    for (int i = 1; i <= 6; i++) begin
      step();
      expect_out($sformatf("idle%0d", i), 8'(i), 1'b0, 1'b0, 8'(i - 1), 1'b1);
    end

    set_in(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("hold%0d", i), 8'h06, 1'b0, 1'b1, 8'h05, 1'b1);
    end
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    step(); expect_out("unhold", 8'h07, 1'b0, 1'b0, 8'h06, 1'b1);
    step(); expect_out("run8",   8'h08, 1'b0, 1'b0, 8'h07, 1'b1);
    step(); expect_out("run9",   8'h09, 1'b0, 1'b0, 8'h08, 1'b1);

    set_in(1'b0, 1'b1, 8'h40, 1'b0);
    step(); expect_out("redir40", 8'h40, 1'b1, 1'b0, 8'h08, 1'b0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    step(); expect_out("flush40", 8'h40, 1'b1, 1'b0, 8'h08, 1'b0);
    step(); expect_out("exit40",  8'h40, 1'b0, 1'b0, 8'h08, 1'b0);
    step(); expect_out("run41",   8'h41, 1'b0, 1'b0, 8'h40, 1'b1);
    step(); expect_out("run42",   8'h42, 1'b0, 1'b0, 8'h41, 1'b1);

    set_in(1'b1, 1'b1, 8'h80, 1'b0);
    step(); expect_out("redir_stall", 8'h80, 1'b1, 1'b0, 8'h41, 1'b0);
    set_in(1'b1, 1'b0, 8'h00, 1'b0);
    step(); expect_out("flush_stall", 8'h80, 1'b1, 1'b0, 8'h41, 1'b0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    step(); expect_out("exit80",      8'h80, 1'b0, 1'b0, 8'h41, 1'b0);
    step(); expect_out("run81",       8'h81, 1'b0, 1'b0, 8'h80, 1'b1);

    set_in(1'b0, 1'b1, 8'h10, 1'b0);
    step(); expect_out("redir10",   8'h10, 1'b1, 1'b0, 8'h80, 1'b0);
    set_in(1'b0, 1'b1, 8'h12, 1'b0);
    step(); expect_out("restart12", 8'h12, 1'b1, 1'b0, 8'h80, 1'b0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    step(); expect_out("flush12",   8'h12, 1'b1, 1'b0, 8'h80, 1'b0);
    step(); expect_out("exit12",    8'h12, 1'b0, 1'b0, 8'h80, 1'b0);

    set_in(1'b0, 1'b0, 8'h00, 1'b1);
    step(); expect_out("halt", 8'h12, 1'b1, 1'b0, 8'h80, 1'b0);
    set_in(1'b1, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("halted%0d", i), 8'h12, 1'b1, 1'b0, 8'h80, 1'b0);
    end
    rst = 1'b0;
    #1;
    expect_out("rst_in_halt", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    rst = 1'b1;

    set_in(1'b0, 1'b1, 8'hFE, 1'b0);
    step(); expect_out("redirFE", 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    step(); expect_out("flushFE", 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0);
    step(); expect_out("exitFE",  8'hFE, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("plus1_FE", 32'(bus.pc_plus1), 32'hFF);
    step(); expect_out("runFF",   8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1);
    chk("plus1_FF", 32'(bus.pc_plus1), 32'h00);
    step(); expect_out("wrap00",  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
    chk("plus1_00", 32'(bus.pc_plus1), 32'h01);

    set_in(1'b1, 1'b0, 8'h00, 1'b0);
    step(); expect_out("hold00a", 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1);
    step(); expect_out("hold00b", 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1);
    rst = 1'b0;
    #1;
    expect_out("rst_in_hold", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    rst = 1'b1;
    step(); expect_out("post_rst", 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
